// File: rtl/track_pkg.sv
// Shared colour constants and region codes for the track background and the sprite mixer.
package track_pkg;

  localparam logic [11:0] GREEN      = 12'h0C0;
  localparam logic [11:0] DARK_GREEN = 12'h060;
  localparam logic [11:0] DESERT     = 12'hEEC;
  localparam logic [11:0] CLAY       = 12'hA52;
  localparam logic [11:0] GRAY       = 12'h999;
  localparam logic [11:0] WHITE      = 12'hFFF;
  localparam logic [11:0] BLACK      = 12'h000;
  localparam logic [11:0] RED        = 12'hF00;

  // Horizontal region a pixel column falls into.
  typedef enum logic [2:0] {
    VERGE,
    BORDER,
    ROAD,
    MARK,
    OUT
  } region_e;

  // Verge palette indexed by game level.
  function automatic logic [11:0] vergeColor(input logic [1:0] lvl);
    case (lvl)
      2'd0:    vergeColor = GREEN;
      2'd1:    vergeColor = DARK_GREEN;
      2'd2:    vergeColor = DESERT;
      default: vergeColor = CLAY;
    endcase
  endfunction

endpackage

// File: rtl/track_scroll_ctr.sv
// Per-frame scroll phase and level latch for the track background.
// Both only move on frame_tick so nothing changes mid-frame.
module track_scroll_ctr
  import track_pkg::*;
#(
  parameter int DASH_PERIOD = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frameTick_i,
  input  logic       pause_i,
  input  logic [3:0] speed_i,
  input  logic [1:0] level_i,
  output logic [7:0] scrollOffset_o,
  output logic [1:0] level_o
);

  localparam logic [8:0] PHASE_MASK = 9'(DASH_PERIOD - 1);

  logic [7:0] scrollOffset_q, scrollOffset_d;
  logic [1:0] level_q, level_d;
  logic [8:0] sum;

  // Advance the phase by speed modulo the dash period; level is only sampled on the tick.
  always_comb begin
    scrollOffset_d = scrollOffset_q;
    level_d        = level_q;
    sum            = {1'b0, scrollOffset_q} + {5'b0, speed_i};
    if (frameTick_i) begin
      level_d = level_i;
      if (!pause_i) begin
        scrollOffset_d = 8'(sum & PHASE_MASK);
      end
    end
  end

  // State registers; reset takes priority over a coincident frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scrollOffset_q <= '0;
      level_q        <= '0;
    end else begin
      scrollOffset_q <= scrollOffset_d;
      level_q        <= level_d;
    end
  end

  assign scrollOffset_o = scrollOffset_q;
  assign level_o        = level_q;

endmodule

// File: rtl/track_scroll_renderer.sv
// Track background generator: verges, borders, gray road and scrolling dashed lane dividers.
// Output colour trails pix_row/pix_col by two clocks.
// Define TRACK_CURB_EN to paint the borders as a scrolling red/white curb instead of black.
module track_scroll_renderer
  import track_pkg::*;
#(
  parameter int G1_END      = 125,
  parameter int BORDER_W    = 4,
  parameter int TRACK_W     = 381,
  parameter int NUM_LANES   = 3,
  parameter int MARK_W      = 4,
  parameter int DASH_PERIOD = 64,
  parameter int DASH_LEN    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_row,
  input  logic [9:0]  pix_col,
  input  logic        video_on,
  input  logic        frame_tick,
  input  logic [1:0]  level,
  input  logic [3:0]  speed,
  input  logic        pause,
  output logic [11:0] track_color_out,
  output logic [7:0]  scroll_offset
);

  localparam int TS     = G1_END + 1 + BORDER_W;
  localparam int TE     = TS + TRACK_W - 1;
  localparam int RB_END = TE + BORDER_W;
  localparam int LANE_W = TRACK_W / NUM_LANES;

  logic [1:0]  level_q;
  int          colInt;
  logic [9:0]  rowDiff;

  region_e     region_d, region_q;
  logic [7:0]  phase_d, phase_q;
  logic        visible_d, visible_q;
  logic [11:0] color_d, color_q;
`ifdef TRACK_CURB_EN
  logic        curbOdd_q;
`endif

  track_scroll_ctr #(
    .DASH_PERIOD(DASH_PERIOD)
  ) u_scroll_ctr (
    .clk           (clk),
    .reset         (reset),
    .frameTick_i   (frame_tick),
    .pause_i       (pause),
    .speed_i       (speed),
    .level_i       (level),
    .scrollOffset_o(scroll_offset),
    .level_o       (level_q)
  );

  assign colInt  = int'(pix_col);
  assign rowDiff = pix_row - {2'b00, scroll_offset};

  // Stage 1 decode: classify the column, compute dash phase, and fold blanking into one flag.
  always_comb begin
    region_d  = VERGE;
    phase_d   = 8'(rowDiff & 10'(DASH_PERIOD - 1));
    visible_d = video_on && (pix_row <= 10'd479) && (pix_col <= 10'd639);
    if (colInt > 639) begin
      region_d = OUT;
    end else if (colInt <= G1_END) begin
      region_d = VERGE;
    end else if (colInt < TS) begin
      region_d = BORDER;
    end else if (colInt <= TE) begin
      region_d = ROAD;
      for (int k = 1; k < NUM_LANES; k++) begin
        if (colInt >= TS + k * LANE_W - MARK_W / 2 &&
            colInt <= TS + k * LANE_W - MARK_W / 2 + MARK_W - 1) begin
          region_d = MARK;
        end
      end
    end else if (colInt <= RB_END) begin
      region_d = BORDER;
    end else begin
      region_d = VERGE;
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_q  <= VERGE;
      phase_q   <= '0;
      visible_q <= 1'b0;
    end else begin
      region_q  <= region_d;
      phase_q   <= phase_d;
      visible_q <= visible_d;
    end
  end

`ifdef TRACK_CURB_EN
  // Curb stripe parity, taken from the same scrolled row so the curb moves with the dashes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curbOdd_q <= 1'b0;
    end else begin
      curbOdd_q <= rowDiff[3];
    end
  end
`endif

  // Stage 2 colour selection with blanking taking priority over every region.
  always_comb begin
    color_d = BLACK;
    if (visible_q) begin
      case (region_q)
        VERGE:  color_d = vergeColor(level_q);
`ifdef TRACK_CURB_EN
        BORDER: color_d = curbOdd_q ? WHITE : RED;
`else
        BORDER: color_d = BLACK;
`endif
        MARK:   color_d = (phase_q < 8'(DASH_LEN)) ? WHITE : GRAY;
        ROAD:   color_d = GRAY;
        default: color_d = BLACK;
      endcase
    end
  end

  // Stage 2 register drives the output directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_q <= BLACK;
    end else begin
      color_q <= color_d;
    end
  end

  assign track_color_out = color_q;

endmodule

// File: tb/tb_track_scroll_renderer.sv
// Self-checking bench for track_scroll_renderer: directed steps plus randomized pixels
// compared against a behavioural colour model with a two-deep expected-value queue.
// Honours TRACK_CURB_EN the same way the design does.
module tb_track_scroll_renderer;

  localparam int G1_END      = 125;
  localparam int BORDER_W    = 4;
  localparam int TRACK_W     = 381;
  localparam int NUM_LANES   = 3;
  localparam int MARK_W      = 4;
  localparam int DASH_PERIOD = 64;
  localparam int DASH_LEN    = 32;

  logic        clk;
  logic        reset;
  logic [9:0]  pix_row;
  logic [9:0]  pix_col;
  logic        video_on;
  logic        frame_tick;
  logic [1:0]  level;
  logic [3:0]  speed;
  logic        pause;
  logic [11:0] track_color_out;
  logic [7:0]  scroll_offset;

  int checks = 0;
  int errors = 0;

  int modelOff;
  int modelLevel;
  logic [11:0] expQ[$];

  track_scroll_renderer #(
    .G1_END(G1_END), .BORDER_W(BORDER_W), .TRACK_W(TRACK_W), .NUM_LANES(NUM_LANES),
    .MARK_W(MARK_W), .DASH_PERIOD(DASH_PERIOD), .DASH_LEN(DASH_LEN)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pix_row        (pix_row),
    .pix_col        (pix_col),
    .video_on       (video_on),
    .frame_tick     (frame_tick),
    .level          (level),
    .speed          (speed),
    .pause          (pause),
    .track_color_out(track_color_out),
    .scroll_offset  (scroll_offset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected colour of a pixel given the scroll phase and level the design sees for it.
  function automatic logic [11:0] refColor(input int row, input int col, input logic vid,
                                           input int off, input int lvl);
    int ts, te, lo, shifted;
    logic [11:0] verge;
    logic [11:0] border;
    logic dashOn;
    ts = G1_END + 1 + BORDER_W;
    te = ts + TRACK_W - 1;
    shifted = row - off + 1024;
    dashOn = ((shifted % DASH_PERIOD) < DASH_LEN);
    case (lvl)
      0:       verge = 12'h0C0;
      1:       verge = 12'h060;
      2:       verge = 12'hEEC;
      default: verge = 12'hA52;
    endcase
`ifdef TRACK_CURB_EN
    border = (((shifted / 8) % 2) == 0) ? 12'hF00 : 12'hFFF;
`else
    border = 12'h000;
`endif
    if (!vid || row > 479 || col > 639) return 12'h000;
    if (col <= G1_END) return verge;
    if (col < ts) return border;
    if (col > te + BORDER_W) return verge;
    if (col > te) return border;
    for (int k = 1; k < NUM_LANES; k++) begin
      lo = ts + k * (TRACK_W / NUM_LANES) - MARK_W / 2;
      if (col >= lo && col < lo + MARK_W) return dashOn ? 12'hFFF : 12'h999;
    end
    return 12'h999;
  endfunction

  task automatic checkOutput(input string tag, input logic [11:0] observed,
                             input logic [11:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One pixel per clock; model state is advanced exactly as the tick takes effect.
  task automatic applyStimulus(input int row, input int col, input logic vid, input logic tick);
    int useLevel;
    pix_row    = 10'(row);
    pix_col    = 10'(col);
    video_on   = vid;
    frame_tick = tick;
    useLevel   = tick ? int'(level) : modelLevel;
    expQ.push_back(refColor(row, col, vid, modelOff, useLevel));
    if (tick) begin
      modelLevel = int'(level);
      if (!pause) modelOff = (modelOff + int'(speed)) % DASH_PERIOD;
    end
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    if (expQ.size() >= 2) checkOutput("pixel", track_color_out, expQ.pop_front());
    checkOutput("scroll", {4'h0, scroll_offset}, 12'(modelOff));
  endtask

  task automatic pixelCheck(input string tag, input int row, input int col, input logic vid,
                            input logic [11:0] expected);
    applyStimulus(row, col, vid, 1'b0);
    applyStimulus(0, 0, 1'b0, 1'b0);
    checkOutput(tag, track_color_out, expected);
  endtask

  // Assert reset between edges, check it clears immediately and holds, then release.
  task automatic midReset();
    pix_row    = 10'd200;
    pix_col    = 10'd300;
    video_on   = 1'b1;
    #2 reset   = 1'b1;
    frame_tick = 1'b1;
    speed      = 4'd5;
    @(posedge clk);
    #1;
    checkOutput("rst_color", track_color_out, 12'h000);
    checkOutput("rst_scroll", {4'h0, scroll_offset}, 12'h000);
    @(posedge clk);
    #1;
    checkOutput("rst_hold", track_color_out, 12'h000);
    frame_tick = 1'b0;
    speed      = 4'd0;
    reset      = 1'b0;
    modelOff   = 0;
    modelLevel = 0;
    expQ.delete();
    expQ.push_back(12'h000);
  endtask

  initial begin
    reset = 1'b1;
    pix_row = '0; pix_col = '0; video_on = 1'b0; frame_tick = 1'b0;
    level = 2'd0; speed = 4'd0; pause = 1'b0;
    modelOff = 0;
    modelLevel = 0;
    @(posedge clk);
    #1;
    checkOutput("init_color", track_color_out, 12'h000);
    checkOutput("init_scroll", {4'h0, scroll_offset}, 12'h000);
    midReset();

    level = 2'd2;
    applyStimulus(0, 0, 1'b0, 1'b1);
    pixelCheck("desert", 100, 10, 1'b1, 12'hEEC);
    level = 2'd3;
    pixelCheck("level_hold", 100, 10, 1'b1, 12'hEEC);

    pixelCheck("dash_on", 10, 257, 1'b1, 12'hFFF);
    pixelCheck("dash_off", 40, 257, 1'b1, 12'h999);
    pixelCheck("road", 10, 300, 1'b1, 12'h999);
    pixelCheck("div1_lo", 5, 255, 1'b1, 12'hFFF);
    pixelCheck("div1_pre", 5, 254, 1'b1, 12'h999);
    pixelCheck("div1_post", 5, 259, 1'b1, 12'h999);
    pixelCheck("video_off", 10, 300, 1'b0, 12'h000);
    pixelCheck("col_700", 10, 700, 1'b1, 12'h000);
    pixelCheck("row_480", 480, 300, 1'b1, 12'h000);
`ifdef TRACK_CURB_EN
    pixelCheck("curb_red", 0, 127, 1'b1, 12'hF00);
    pixelCheck("curb_white", 8, 127, 1'b1, 12'hFFF);
`else
    pixelCheck("border", 0, 127, 1'b1, 12'h000);
    pixelCheck("border_r", 0, 512, 1'b1, 12'h000);
`endif

    speed = 4'd15;
    repeat (5) applyStimulus(0, 0, 1'b0, 1'b1);
    checkOutput("scroll_75", {4'h0, scroll_offset}, 12'd11);
    pause = 1'b1;
    applyStimulus(0, 0, 1'b0, 1'b1);
    checkOutput("scroll_pause", {4'h0, scroll_offset}, 12'd11);
    pause = 1'b0;

    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 700; c++) applyStimulus(r * 37 + 3, c, 1'b1, 1'b0);
      applyStimulus(0, 0, 1'b0, 1'b1);
    end

    repeat (4000) begin
      level = 2'($urandom_range(0, 3));
      speed = 4'($urandom_range(0, 15));
      pause = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 520), $urandom_range(0, 700),
                    ($urandom_range(0, 7) != 0), ($urandom_range(0, 30) == 0));
    end

    midReset();
    repeat (500) begin
      level = 2'($urandom_range(0, 3));
      speed = 4'($urandom_range(0, 15));
      pause = ($urandom_range(0, 3) == 0);
      applyStimulus($urandom_range(0, 479), $urandom_range(0, 639), 1'b1,
                    ($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
